// File: rtl/mp3_ctrl_panel_if.sv
// Front-panel interface of the VS1003 control block: raw buttons and the player
// finish level in, and the registered player-control words out.
interface mp3_ctrl_panel_if;
  logic        i_btn_next;
  logic        i_btn_prev;
  logic        i_btn_pause;
  logic        i_btn_vol_up;
  logic        i_btn_vol_down;
  logic        i_btn_effect;
  logic        i_finish_song;
  logic [2:0]  o_song_select;
  logic        o_pause;
  logic [15:0] o_vol;
  logic [15:0] o_effect;
  logic [3:0]  o_vol_level;

  modport master (
    output i_btn_next, i_btn_prev, i_btn_pause, i_btn_vol_up, i_btn_vol_down,
           i_btn_effect, i_finish_song,
    input  o_song_select, o_pause, o_vol, o_effect, o_vol_level
  );

  modport slave (
    input  i_btn_next, i_btn_prev, i_btn_pause, i_btn_vol_up, i_btn_vol_down,
           i_btn_effect, i_finish_song,
    output o_song_select, o_pause, o_vol, o_effect, o_vol_level
  );
endinterface

// File: rtl/mp3_ctrl_panel.sv
// Debounces the front-panel buttons and turns presses plus the player's
// end-of-song event into stable song, pause, volume and bass/treble words.
module mp3_ctrl_panel #(
  parameter int         DEBOUNCE_CYCLES = 2000000,
  parameter int         NUM_SONGS       = 4,
  parameter logic [7:0] VOL_STEP        = 8'h10,
  parameter logic [7:0] VOL_INIT        = 8'h40,
  parameter logic [7:0] VOL_MAX_ATT     = 8'hFE
) (
  input logic             clk,
  input logic             rst_n,
  mp3_ctrl_panel_if.slave bus
);

  localparam int              CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]      SONG_LAST = 3'(NUM_SONGS - 1);

  // Button order: 0 next, 1 prev, 2 pause, 3 vol_up, 4 vol_down, 5 effect.
  logic [5:0]    btn_raw;
  logic [5:0]    sync1, sync2, stable, stable_q;
  logic [CW-1:0] cnt [6];
  logic [5:0]    press;

  logic          fin_s1, fin_s2, fin_q;
  logic          finish_edge;

  logic [2:0]    song_q, song_d;
  logic          pause_q, pause_d;
  logic [7:0]    att_q, att_d;
  logic [1:0]    eidx_q, eidx_d;
  logic [15:0]   effect_q, effect_d;

  logic          adv, back;

  assign btn_raw = {bus.i_btn_effect, bus.i_btn_vol_down, bus.i_btn_vol_up,
                    bus.i_btn_pause, bus.i_btn_prev, bus.i_btn_next};

  // NOTE: sequential state uses <= so every flop samples pre-edge values; the
  // synchronizer chain only works because sync2 sees the old sync1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_q;

  // The player's finish level is already clean, so only synchronize and edge-detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_s1 <= 1'b0;
      fin_s2 <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      fin_s1 <= bus.i_finish_song;
      fin_s2 <= fin_s1;
      fin_q  <= fin_s2;
    end
  end

  assign finish_edge = fin_s2 & ~fin_q;
  assign adv         = press[0] | finish_edge;
  assign back        = press[1];

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which keeps this block free of inferred latches.
  always_comb begin
    song_d   = song_q;
    pause_d  = pause_q;
    att_d    = att_q;
    eidx_d   = eidx_q;
    effect_d = effect_q;

    if (adv && !back)
      song_d = (song_q == SONG_LAST) ? 3'd0 : song_q + 3'd1;
    else if (back && !adv)
      song_d = (song_q == 3'd0) ? SONG_LAST : song_q - 3'd1;

    // A song change always resumes playback and wins over a same-cycle pause press.
    if (adv != back)
      pause_d = 1'b0;
    else if (press[2])
      pause_d = ~pause_q;

    if (press[3] && !press[4])
      att_d = (att_q < VOL_STEP) ? 8'h00 : att_q - VOL_STEP;
    else if (press[4] && !press[3])
      att_d = (att_q > VOL_MAX_ATT - VOL_STEP) ? VOL_MAX_ATT : att_q + VOL_STEP;

    if (press[5]) begin
      eidx_d = eidx_q + 2'd1;
      unique case (eidx_d)
        2'd0: effect_d = 16'h0000;
        2'd1: effect_d = 16'h00F6;
        2'd2: effect_d = 16'h7A00;
        2'd3: effect_d = 16'h7AF6;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_q   <= 3'd0;
      pause_q  <= 1'b0;
      att_q    <= VOL_INIT;
      eidx_q   <= 2'd0;
      effect_q <= 16'h0000;
    end else begin
      song_q   <= song_d;
      pause_q  <= pause_d;
      att_q    <= att_d;
      eidx_q   <= eidx_d;
      effect_q <= effect_d;
    end
  end

  assign bus.o_song_select = song_q;
  assign bus.o_pause       = pause_q;
  assign bus.o_vol         = {att_q, att_q};
  assign bus.o_vol_level   = att_q[7:4];
  assign bus.o_effect      = effect_q;

endmodule
